// File: rtl/neopix_frame_reader.sv
// neopix_frame_reader: reads NUM_LEDS pixel words from the frame RAM and serialises them onto a WS2812 line.
// Define NEOPIX_RGBW_EN for 32-bit GRBW pixels; the default build sends 24-bit GRB from q[23:0].
module neopix_frame_reader #(
    parameter int NUM_LEDS  = 8,
    parameter int T0H_CYC   = 20,
    parameter int T1H_CYC   = 40,
    parameter int BIT_CYC   = 63,
    parameter int LATCH_CYC = 2500
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic [8:0]  rdaddress,
    input  logic [31:0] q,
    output logic        busy,
    output logic        done,
    output logic        dout
);
`ifdef NEOPIX_RGBW_EN
    localparam int PIX_BITS = 32;
`else
    localparam int PIX_BITS = 24;
    logic unused_q_hi;
    assign unused_q_hi = ^q[31:24];
`endif
    localparam int CNT_MAX = (LATCH_CYC > BIT_CYC) ? LATCH_CYC : BIT_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] FETCH_LAST = CW'(2);
    localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYC - 1);
    localparam logic [CW-1:0] T0H        = CW'(T0H_CYC);
    localparam logic [CW-1:0] T1H        = CW'(T1H_CYC);
    localparam logic [4:0]    BITS_LAST  = 5'(PIX_BITS - 1);
    localparam logic [9:0]    IDX_LAST   = 10'(NUM_LEDS - 1);
    localparam logic [8:0]    FIRST_PREFETCH = (NUM_LEDS > 1) ? 9'd1 : 9'd0;

    typedef enum logic [1:0] {IDLE, FETCH, SEND, LATCH} state_t;

    state_t              state;
    logic [PIX_BITS-1:0] shreg;
    logic [CW-1:0]       cyc;
    logic [4:0]          bitcnt;
    logic [8:0]          index;

    logic [CW-1:0] cyc_next;
    logic [CW-1:0] high_len;
    logic [9:0]    prefetch_addr;

    // rdaddress always points one pixel ahead, clamped to the last pixel of the frame
    always_comb begin
        cyc_next      = cyc + 1'b1;
        high_len      = shreg[PIX_BITS-1] ? T1H : T0H;
        prefetch_addr = {1'b0, index} + 10'd2;
        if (prefetch_addr > IDX_LAST)
            prefetch_addr = IDX_LAST;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            dout      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rdaddress <= '0;
            index     <= '0;
            cyc       <= '0;
            bitcnt    <= '0;
            shreg     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rdaddress <= '0;
                        busy      <= 1'b1;
                        cyc       <= '0;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (cyc == FETCH_LAST) begin
                        shreg     <= q[PIX_BITS-1:0];
                        rdaddress <= FIRST_PREFETCH;
                        index     <= '0;
                        bitcnt    <= '0;
                        cyc       <= '0;
                        dout      <= 1'b1;
                        state     <= SEND;
                    end else begin
                        cyc <= cyc_next;
                    end
                end
                SEND: begin
                    if (cyc == BIT_LAST) begin
                        cyc <= '0;
                        if (bitcnt != BITS_LAST) begin
                            bitcnt <= bitcnt + 5'd1;
                            shreg  <= shreg << 1;
                            dout   <= 1'b1;
                        end else if ({1'b0, index} < IDX_LAST) begin
                            bitcnt    <= '0;
                            shreg     <= q[PIX_BITS-1:0];
                            index     <= index + 9'd1;
                            rdaddress <= prefetch_addr[8:0];
                            dout      <= 1'b1;
                        end else begin
                            dout  <= 1'b0;
                            state <= LATCH;
                        end
                    end else begin
                        cyc  <= cyc_next;
                        dout <= (cyc_next < high_len);
                    end
                end
                LATCH: begin
                    if (cyc == LATCH_LAST) begin
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        rdaddress <= '0;
                        index     <= '0;
                        cyc       <= '0;
                        state     <= IDLE;
                    end else begin
                        cyc <= cyc_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
